id_stage_pipe: RTL and testbench

//  Pipelined decode stage: parametrised successor of the single-cycle decode stage.

---
 rtl/id_stage_pipe_pkg.sv | 23 ++
 rtl/id_stage_pipe_regfile.sv | 46 ++++
 rtl/id_stage_pipe.sv | 151 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared encodings for the pipelined decode stage: PC source select,
// branch kinds and instruction field positions.
package id_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10
  } br_e;

  // Register fields are 5 bits wide; imm16 overlaps func and rd.
  localparam int IMM_MSB = 25;
  localparam int IMM_LSB = 10;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 5;
  localparam int RT_LSB  = 0;
  localparam int JIDX_W  = 26;

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// NREG x XLEN register file, two combinational read ports, one write port.
// A read of the register being written this cycle returns the new value.
module regfile_sync #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            we,
  input  logic [AW-1:0]   wn,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra_a,
  input  logic [AW-1:0]   ra_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wn != '0) begin
      regs[wn] <= wd;
    end
  end

  logic [AW-1:0]   ra   [2];
  logic [XLEN-1:0] rout [2];

  assign ra[0]   = ra_a;
  assign ra[1]   = ra_b;
  assign rdata_a = rout[0];
  assign rdata_b = rout[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign rout[gi] = (ra[gi] == '0)            ? '0 :
                        (we && wn == ra[gi])      ? wd :
                                                    regs[ra[gi]];
    end
  endgenerate

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: field decode, register file, operand forwarding,
// load-use stall detection, branch/jump resolution and the ID/EX register.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int ACW  = 3,
  parameter int FWD  = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [XLEN-1:0] pc4,
  input  logic [31:0]     inst,
  input  logic            if_valid,
  input  logic            cu_wreg,
  input  logic            cu_m2reg,
  input  logic            cu_wmem,
  input  logic [ACW-1:0]  cu_aluc,
  input  logic            cu_aluimm,
  input  logic            cu_shift,
  input  logic            cu_regrt,
  input  logic            cu_sext,
  input  logic [1:0]      cu_br,
  input  logic            cu_jmp,
  input  logic [XLEN-1:0] ex_alu,
  input  logic            mem_wreg,
  input  logic            mem_m2reg,
  input  logic [AW-1:0]   mem_rn,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wreg,
  input  logic [AW-1:0]   wb_rn,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            if_flush,
  output logic [1:0]      pcsource,
  output logic [XLEN-1:0] bpc,
  output logic [XLEN-1:0] jpc,
  output logic            e_valid,
  output logic            e_wreg,
  output logic            e_m2reg,
  output logic            e_wmem,
  output logic            e_aluimm,
  output logic            e_shift,
  output logic [ACW-1:0]  e_aluc,
  output logic [XLEN-1:0] e_a,
  output logic [XLEN-1:0] e_b,
  output logic [XLEN-1:0] e_imm,
  output logic [AW-1:0]   e_rn
);

  localparam bit FWD_ON = (FWD != 0);

  logic [AW-1:0]   rs, rt, rd, rn;
  logic [XLEN-1:0] imm, rf_a, rf_b;
  br_e             br;
  logic            is_branch;

  assign rs        = inst[RS_LSB +: AW];
  assign rt        = inst[RT_LSB +: AW];
  assign rd        = inst[RD_LSB +: AW];
  assign rn        = cu_regrt ? rt : rd;
  assign imm       = {{(XLEN-16){cu_sext & inst[IMM_MSB]}}, inst[IMM_MSB:IMM_LSB]};
  assign bpc       = pc4 + (imm << 2);
  assign jpc       = {pc4[XLEN-1:28], inst[JIDX_W-1:0], 2'b00};
  assign br        = br_e'(cu_br);
  assign is_branch = (br == BR_BEQ) || (br == BR_BNE);

  logic unused_op;
  assign unused_op = ^inst[31:26];

  regfile_sync #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk     (clk),
    .srst    (clrn),
    .we      (wb_wreg),
    .wn      (wb_rn),
    .wd      (wb_data),
    .ra_a    (rs),
    .ra_b    (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  logic [AW-1:0]   src  [2];
  logic [XLEN-1:0] rf_q [2];
  logic [XLEN-1:0] opnd [2];
  logic [1:0]      e_match, ex_fwd, mem_match, ld_hz, mem_ld_hz, raw_hz;

  assign src[0]  = rs;
  assign src[1]  = rt;
  assign rf_q[0] = rf_a;
  assign rf_q[1] = rf_b;

  // rs and rt resolve identically; r0 never matches a producer.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      assign e_match[gi]   = e_valid && (e_rn == src[gi]) && (src[gi] != '0);
      assign ex_fwd[gi]    = e_match[gi] && e_wreg && !e_m2reg;
      assign mem_match[gi] = mem_wreg && (mem_rn == src[gi]) && (src[gi] != '0);
      assign ld_hz[gi]     = e_match[gi] && e_m2reg;
      // Loaded data arrives too late in the cycle for the ID equality compare.
      assign mem_ld_hz[gi] = is_branch && mem_m2reg && (mem_rn == src[gi]) && (src[gi] != '0);
      assign raw_hz[gi]    = (e_match[gi] && e_wreg) || mem_match[gi];
      assign opnd[gi]      = (src[gi] == '0) ? '0 :
                             ex_fwd[gi]      ? ex_alu :
                             mem_match[gi]   ? mem_data :
                                               rf_q[gi];
    end
  endgenerate

  logic hazard, rsrtequ, taken;

  assign hazard   = (|ld_hz) || (|mem_ld_hz) || (!FWD_ON && (|raw_hz));
  assign stall    = if_valid && hazard;
  assign rsrtequ  = (opnd[0] == opnd[1]);
  assign taken    = if_valid && !hazard &&
                    (((br == BR_BEQ) && rsrtequ) || ((br == BR_BNE) && !rsrtequ) || cu_jmp);
  assign if_flush = taken;
  assign pcsource = !taken ? PCSRC_SEQ : (cu_jmp ? PCSRC_JMP : PCSRC_BR);

  always_ff @(posedge clk) begin
    if (clrn || stall || !if_valid) begin
      e_valid  <= 1'b0;
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
      e_aluimm <= 1'b0;
      e_shift  <= 1'b0;
      e_aluc   <= '0;
      e_a      <= '0;
      e_b      <= '0;
      e_imm    <= '0;
      e_rn     <= '0;
    end else begin
      e_valid  <= 1'b1;
      e_wreg   <= cu_wreg && (rn != '0);
      e_m2reg  <= cu_m2reg;
      e_wmem   <= cu_wmem;
      e_aluimm <= cu_aluimm;
      e_shift  <= cu_shift;
      e_aluc   <= cu_aluc;
      e_a      <= opnd[0];
      e_b      <= opnd[1];
      e_imm    <= imm;
      e_rn     <= rn;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: the driver pushes hand-computed ID/EX
// contents into a queue, a monitor pops and compares on every e_valid cycle.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] pc4, inst;
  logic        if_valid;
  logic        cu_wreg, cu_m2reg, cu_wmem, cu_aluimm, cu_shift, cu_regrt, cu_sext, cu_jmp;
  logic [2:0]  cu_aluc;
  logic [1:0]  cu_br;
  logic [31:0] ex_alu, mem_data, wb_data;
  logic        mem_wreg, mem_m2reg, wb_wreg;
  logic [4:0]  mem_rn, wb_rn;
  logic        stall, if_flush;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc;
  logic        e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift;
  logic [2:0]  e_aluc;
  logic [31:0] e_a, e_b, e_imm;
  logic [4:0]  e_rn;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .clrn(clrn), .pc4(pc4), .inst(inst), .if_valid(if_valid),
    .cu_wreg(cu_wreg), .cu_m2reg(cu_m2reg), .cu_wmem(cu_wmem), .cu_aluc(cu_aluc),
    .cu_aluimm(cu_aluimm), .cu_shift(cu_shift), .cu_regrt(cu_regrt), .cu_sext(cu_sext),
    .cu_br(cu_br), .cu_jmp(cu_jmp), .ex_alu(ex_alu),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn), .mem_data(mem_data),
    .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data),
    .stall(stall), .if_flush(if_flush), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
    .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
    .e_aluimm(e_aluimm), .e_shift(e_shift), .e_aluc(e_aluc),
    .e_a(e_a), .e_b(e_b), .e_imm(e_imm), .e_rn(e_rn)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rn;
    logic [7:0]  ctl;  // {wreg, m2reg, wmem, aluimm, shift, aluc[2:0]}
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [7:0] CTL_NONE = 8'b0000_0000;
  localparam logic [7:0] CTL_ADD  = 8'b1000_0010;
  localparam logic [7:0] CTL_LW   = 8'b1101_0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm16,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, imm16, rs, rt};
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic [4:0] rn, input logic [7:0] ctl);
    exp_t e;
    e.a = a; e.b = b; e.imm = imm; e.rn = rn; e.ctl = ctl;
    q.push_back(e);
  endtask

  task automatic set_cu(input logic wreg, input logic m2reg, input logic aluimm,
                        input logic regrt, input logic sext, input logic [2:0] aluc,
                        input logic [1:0] br, input logic jmp);
    cu_wreg = wreg; cu_m2reg = m2reg; cu_wmem = 1'b0; cu_aluimm = aluimm; cu_shift = 1'b0;
    cu_regrt = regrt; cu_sext = sext; cu_aluc = aluc; cu_br = br; cu_jmp = jmp;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison set per registered ID/EX transaction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (e_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_txn actual=e_valid=1 required=no transaction t=%0t", $time);
        end else begin
          e = q.pop_front();
          chk("e_a", e_a, e.a);
          chk("e_b", e_b, e.b);
          chk("e_imm", e_imm, e.imm);
          chk("e_rn", 32'(e_rn), 32'(e.rn));
          chk("e_ctl", 32'({e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_aluc}), 32'(e.ctl));
          $display("txn t=%0t a=%h b=%h imm=%h rn=%0d", $time, e_a, e_b, e_imm, e_rn);
        end
      end
    end
  end

  initial begin
    clrn = 1'b1; pc4 = '0; inst = '0; if_valid = 1'b0;
    set_cu(0, 0, 0, 0, 0, 3'd0, 2'b00, 0);
    ex_alu = '0; mem_wreg = 0; mem_m2reg = 0; mem_rn = '0; mem_data = '0;
    wb_wreg = 0; wb_rn = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_e_valid", 32'(e_valid), 0);
    chk("rst_e_wreg", 32'(e_wreg), 0);
    chk("rst_e_a", e_a, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_pcsource", 32'(pcsource), 0);

    // r0 write attempt; read r0 and never-written r5; rd=0 forces wreg off
    clrn = 1'b0; if_valid = 1'b1;
    wb_wreg = 1; wb_rn = 5'd0; wb_data = 32'd5;
    inst = mk(6'h00, 16'h0000, 5'd0, 5'd5);
    set_cu(1, 0, 0, 0, 0, 3'd1, 2'b00, 0);
    push(0, 0, 0, 5'd0, 8'b0000_0001);
    #2 chk("r0_stall", 32'(stall), 0);
    next();
    wb_rn = 5'd1; wb_data = 32'd9;
    inst = mk(6'h00, 16'h0000, 5'd0, 5'd0);
    set_cu(0, 0, 0, 0, 0, 3'd0, 2'b00, 0);
    push(0, 0, 0, 5'd0, CTL_NONE);
    next();
    wb_rn = 5'd2; if_valid = 1'b0;
    next();
    wb_wreg = 0; if_valid = 1'b1;

    // add r3 = r1 + r2
    inst = mk(6'h00, 16'h0003, 5'd1, 5'd2);
    set_cu(1, 0, 0, 0, 0, 3'd2, 2'b00, 0);
    push(9, 9, 32'h3, 5'd3, CTL_ADD);
    #2 chk("add_stall", 32'(stall), 0);
    next();
    // consumer of r3: EX forward beats a MEM claim on r3
    inst = mk(6'h00, 16'h0007, 5'd3, 5'd1);
    ex_alu = 32'd7; mem_wreg = 1; mem_rn = 5'd3; mem_data = 32'hAA;
    push(7, 9, 32'h7, 5'd7, CTL_ADD);
    #2 chk("exfwd_stall", 32'(stall), 0);
    next();
    // MEM forward of r3 on both operands
    inst = mk(6'h00, 16'h0008, 5'd3, 5'd3);
    ex_alu = 32'hDEAD; mem_data = 32'h33;
    push(32'h33, 32'h33, 32'h8, 5'd8, CTL_ADD);
    next();

    // lw r4, 0x10(r1) followed by a use of r4
    mem_wreg = 0;
    inst = mk(6'h23, 16'h0010, 5'd1, 5'd4);
    set_cu(1, 1, 1, 1, 1, 3'd0, 2'b00, 0);
    push(9, 0, 32'h10, 5'd4, CTL_LW);
    next();
    inst = mk(6'h00, 16'h0009, 5'd1, 5'd4);
    set_cu(1, 0, 0, 0, 0, 3'd2, 2'b00, 0);
    #2;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_pcsource", 32'(pcsource), 0);
    chk("lu_flush", 32'(if_flush), 0);
    next();
    chk("lu_bubble", 32'(e_valid), 0);
    mem_wreg = 1; mem_m2reg = 1; mem_rn = 5'd4; mem_data = 32'h44;
    push(9, 32'h44, 32'h9, 5'd9, CTL_ADD);
    #2 chk("lu_release", 32'(stall), 0);
    next();

    // beq r1, r2 (equal), imm 3
    mem_wreg = 0; mem_m2reg = 0; pc4 = 32'h100;
    inst = mk(6'h04, 16'h0003, 5'd1, 5'd2);
    set_cu(0, 0, 0, 0, 1, 3'd0, 2'b01, 0);
    push(9, 9, 32'h3, 5'd3, CTL_NONE);
    #2;
    chk("beq_pcsource", 32'(pcsource), 1);
    chk("beq_bpc", bpc, 32'h10C);
    chk("beq_flush", 32'(if_flush), 1);
    chk("beq_stall", 32'(stall), 0);
    next();
    // branch source still being loaded in MEM
    mem_wreg = 1; mem_m2reg = 1; mem_rn = 5'd1; mem_data = 32'h77;
    #2;
    chk("brmem_stall", 32'(stall), 1);
    chk("brmem_pcsource", 32'(pcsource), 0);
    chk("brmem_flush", 32'(if_flush), 0);
    next();

    // bne r1 (9) vs r5 (0), sign-extended -1
    mem_wreg = 0; mem_m2reg = 0;
    inst = mk(6'h05, 16'hFFFF, 5'd1, 5'd5);
    set_cu(0, 0, 0, 0, 1, 3'd0, 2'b10, 0);
    push(9, 0, 32'hFFFF_FFFF, 5'd31, CTL_NONE);
    #2;
    chk("bne_bpc", bpc, 32'h0000_00FC);
    chk("bne_pcsource", 32'(pcsource), 1);
    chk("bne_flush", 32'(if_flush), 1);
    next();
    // bne on equal operands, zero-extended
    inst = mk(6'h05, 16'hFFFF, 5'd1, 5'd2);
    cu_sext = 0;
    push(9, 9, 32'h0000_FFFF, 5'd31, CTL_NONE);
    #2;
    chk("bneq_pcsource", 32'(pcsource), 0);
    chk("bneq_flush", 32'(if_flush), 0);
    chk("bneq_bpc", bpc, 32'h0004_00FC);
    next();

    // jump, target index 0x40
    pc4 = 32'h1000_0004;
    inst = {6'h02, 26'h40};
    set_cu(0, 0, 0, 0, 0, 3'd0, 2'b00, 1);
    push(9, 0, 32'h0, 5'd0, CTL_NONE);
    #2;
    chk("jmp_pcsource", 32'(pcsource), 2);
    chk("jmp_jpc", jpc, 32'h1000_0100);
    chk("jmp_flush", 32'(if_flush), 1);
    next();

    // WB write-through of r6, then a plain regfile read of it
    pc4 = '0;
    wb_wreg = 1; wb_rn = 5'd6; wb_data = 32'h55;
    inst = mk(6'h00, 16'h000A, 5'd6, 5'd1);
    set_cu(1, 0, 0, 0, 0, 3'd2, 2'b00, 0);
    push(32'h55, 9, 32'hA, 5'd10, CTL_ADD);
    next();
    wb_wreg = 0;
    inst = mk(6'h00, 16'h000B, 5'd1, 5'd6);
    push(9, 32'h55, 32'hB, 5'd11, CTL_ADD);
    next();

    // reset arriving during a load-use stall
    inst = mk(6'h23, 16'h0010, 5'd1, 5'd4);
    set_cu(1, 1, 1, 1, 1, 3'd0, 2'b00, 0);
    push(9, 0, 32'h10, 5'd4, CTL_LW);
    next();
    inst = mk(6'h00, 16'h0009, 5'd1, 5'd4);
    set_cu(1, 0, 0, 0, 0, 3'd2, 2'b00, 0);
    #2 chk("rs_stall_before", 32'(stall), 1);
    clrn = 1'b1;
    next();
    #2;
    chk("rs_e_valid", 32'(e_valid), 0);
    chk("rs_stall_after", 32'(stall), 0);
    clrn = 1'b0;
    push(0, 0, 32'h9, 5'd9, CTL_ADD);
    next();
    if_valid = 1'b0;
    next();
    next();

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
